// File: rtl/shift_pkg.sv
// Shared types for the shifter arbiter: request descriptor and slot state.
package shift_pkg;

   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned XLEN    = 32;

   typedef struct packed {
      logic               sr;
      logic               arith;
      logic [SHAMT_W-1:0] shamt;
      logic [XLEN-1:0]    data;
   } shift_req_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Single combinational barrel shifter: SLL, SRL or SRA selected by sr/arith.
module shifter
   import shift_pkg::*;
(
   input  logic               sr,
   input  logic               arith,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [XLEN-1:0]    data_in,
   output logic [XLEN-1:0]    data_out
);

   always_comb begin
      data_out = '0;
      if (!sr) begin
         data_out = data_in << shamt;
      end else if (arith) begin
         data_out = $unsigned($signed(data_in) >>> shamt);
      end else begin
         data_out = data_in >> shamt;
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between NREQ requesters, with a
// single registered result slot routed back to the winning requester.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  shift_req_t [NREQ-1:0]       req_op,
   output logic [NREQ-1:0]             rsp_valid,
   input  logic [NREQ-1:0]             rsp_ready,
   output logic [XLEN-1:0]             rsp_data
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   slot_state_t      state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [XLEN-1:0]  slot_data;
   logic [NREQ-1:0]  rsp_valid_q;

   logic             drain;
   logic             slot_free;
   logic             arb_en;
   logic [PTR_W-1:0] grant_idx;
   logic [NREQ-1:0]  grant_vec;
   logic             accept;
   shift_req_t       sel_op;
   logic [XLEN-1:0]  shift_out;

   // First valid requester after ptr, wrapping modulo NREQ.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] pick;
      logic             found;
      int unsigned      idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && valid[idx]) begin
            pick  = PTR_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign drain     = (state == SLOT_FULL) && ((rsp_valid_q & rsp_ready) != '0);
   assign slot_free = (state == SLOT_EMPTY) || drain;
   assign arb_en    = rst_n && !flush && slot_free && (req_valid != '0);
   assign grant_idx = rr_pick(req_valid, rr_ptr);

   always_comb begin
      grant_vec = '0;
      if (arb_en) begin
         grant_vec = NREQ'(1) << grant_idx;
      end
   end

   assign req_ready = grant_vec;
   assign accept    = (grant_vec != '0);
   assign sel_op    = req_op[grant_idx];

   shifter u_shifter (
      .sr       (sel_op.sr),
      .arith    (sel_op.arith),
      .shamt    (sel_op.shamt),
      .data_in  (sel_op.data),
      .data_out (shift_out)
   );

   // Flush beats accept and drain; a drain with accept keeps the slot FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SLOT_EMPTY;
         rr_ptr      <= PTR_W'(NREQ - 1);
         owner       <= '0;
         slot_data   <= '0;
         rsp_valid_q <= '0;
      end else if (flush) begin
         state       <= SLOT_EMPTY;
         rsp_valid_q <= '0;
      end else if (accept) begin
         state       <= SLOT_FULL;
         slot_data   <= shift_out;
         owner       <= grant_idx;
         rr_ptr      <= grant_idx;
         rsp_valid_q <= grant_vec;
      end else if (drain) begin
         state       <= SLOT_EMPTY;
         rsp_valid_q <= '0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = slot_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (NREQ=2): directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_shift_arbiter;
   import shift_pkg::*;

   localparam int unsigned NREQ = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  flush;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   shift_req_t [NREQ-1:0] req_op;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [XLEN-1:0]       rsp_data;

   int errors = 0;
   int checks = 0;

   shift_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference shift built from division/multiplication by powers of two.
   function automatic logic [31:0] ref_shift(input shift_req_t op);
      longint unsigned p;
      longint unsigned d;
      p = 64'd1 << op.shamt;
      d = {32'd0, op.data};
      if (!op.sr) return 32'((d * p) % 64'h1_0000_0000);
      if (!op.arith || !op.data[31]) return 32'(d / p);
      return 32'(64'hFFFF_FFFF - ((64'hFFFF_FFFF - d) / p));
   endfunction

   function automatic shift_req_t mk(input logic sr, input logic ar,
                                     input logic [4:0] sh, input logic [31:0] d);
      shift_req_t o;
      o.sr = sr; o.arith = ar; o.shamt = sh; o.data = d;
      return o;
   endfunction

   // Bus-level invariants sampled on the falling edge.
   logic            prev_stall = 1'b0;
   logic [XLEN-1:0] prev_data  = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (!$onehot0(req_ready)) begin
            errors++; $display("FAIL onehot_req_ready got=%b", req_ready);
         end
         checks++;
         if (!$onehot0(rsp_valid)) begin
            errors++; $display("FAIL onehot_rsp_valid got=%b", rsp_valid);
         end
         checks++;
         if ((req_ready & ~req_valid) != '0) begin
            errors++; $display("FAIL ready_without_valid ready=%b valid=%b", req_ready, req_valid);
         end
         if (prev_stall) begin
            checks++;
            if (rsp_data !== prev_data) begin
               errors++; $display("FAIL stall_stable got=%h want=%h", rsp_data, prev_data);
            end
         end
      end
      prev_stall = rst_n && !flush && ((rsp_valid & ~rsp_ready) != '0);
      prev_data  = rsp_data;
   end

   task automatic idle_inputs();
      flush = 1'b0; req_valid = '0; rsp_ready = '0;
      req_op[0] = '0; req_op[1] = '0;
   endtask

   // Leaves time at posedge+1 with reset released.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
      checks++;
      if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
      step();
   endtask

   task automatic test_sll();
      do_reset();
      req_valid = 2'b01; req_op[0] = mk(1'b0, 1'b0, 5'd4, 32'h0000_00F1); rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL sll_ready got=%b want=01", req_ready); end
      step();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sll_rsp_valid got=%b want=01", rsp_valid); end
      checks++;
      if (rsp_data !== 32'h0000_0F10) begin errors++; $display("FAIL sll_data got=%h want=00000f10", rsp_data); end
      step();
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sll_drain got=%b want=00", rsp_valid); end
   endtask

   task automatic test_sra_srl();
      shift_req_t  ops [3];
      logic [31:0] want [3];
      ops[0] = mk(1'b1, 1'b1, 5'd8,  32'h8000_0000); want[0] = 32'hFF80_0000;
      ops[1] = mk(1'b1, 1'b0, 5'd8,  32'h8000_0000); want[1] = 32'h0080_0000;
      ops[2] = mk(1'b1, 1'b1, 5'd31, 32'h8000_0000); want[2] = 32'hFFFF_FFFF;
      rsp_ready = 2'b11;
      for (int i = 0; i < 3; i++) begin
         req_valid = 2'b10; req_op[1] = ops[i];
         #1;
         checks++;
         if (req_ready !== 2'b10) begin errors++; $display("FAIL sr_ready[%0d] got=%b want=10", i, req_ready); end
         step();
         checks++;
         if (rsp_valid !== 2'b10 || rsp_data !== want[i]) begin
            errors++; $display("FAIL sr_result[%0d] valid=%b data=%h want 10/%h", i, rsp_valid, rsp_data, want[i]);
         end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_fairness();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req_op[0] = mk(1'b0, 1'b0, 5'd1, 32'h1); req_op[1] = mk(1'b0, 1'b0, 5'd2, 32'h1);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req_ready !== exp_g[i]) begin errors++; $display("FAIL fair_grant[%0d] got=%b want=%b", i, req_ready, exp_g[i]); end
         step();
         checks++;
         if (rsp_valid !== exp_g[i]) begin errors++; $display("FAIL fair_owner[%0d] got=%b want=%b", i, rsp_valid, exp_g[i]); end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      do_reset();
      req_op[0] = mk(1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF);
      req_op[1] = mk(1'b0, 1'b0, 5'd16, 32'h0000_1234);
      held = ref_shift(req_op[0]);
      req_valid = 2'b01; rsp_ready = 2'b00;
      step();
      req_valid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_data !== held) begin
            errors++;
            $display("FAIL bp_stall[%0d] ready=%b valid=%b data=%h want 00/01/%h", i, req_ready, rsp_valid, rsp_data, held);
         end
         step();
      end
      rsp_ready = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_grant got=%b want=10", req_ready); end
      step();
      req_valid = '0; rsp_ready = 2'b11;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'h1234_0000) begin
         errors++; $display("FAIL bp_next valid=%b data=%h want 10/12340000", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_flush();
      do_reset();
      req_op[0] = mk(1'b0, 1'b0, 5'd1, 32'h0000_0003);
      req_op[1] = mk(1'b1, 1'b0, 5'd1, 32'h0000_0010);
      req_valid = 2'b10; rsp_ready = 2'b00;
      step();
      checks++;
      if (rsp_valid !== 2'b10) begin errors++; $display("FAIL flush_setup got=%b want=10", rsp_valid); end
      flush = 1'b1; req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready got=%b want=00", req_ready); end
      step();
      flush = 1'b0;
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL flush_empty got=%b want=00", rsp_valid); end
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_regrant got=%b want=01", req_ready); end
      step();
      req_valid = '0; rsp_ready = 2'b11;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h6) begin
         errors++; $display("FAIL flush_result valid=%b data=%h want 01/6", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      req_op[0] = mk(1'b0, 1'b0, 5'd0, 32'hCAFE_0001);
      req_op[1] = mk(1'b0, 1'b0, 5'd0, 32'hCAFE_0002);
      req_valid = 2'b10; rsp_ready = 2'b00;
      step();
      req_valid = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || req_ready !== 2'b00) begin
         errors++; $display("FAIL async_reset valid=%b data=%h ready=%b want 00/0/00", rsp_valid, rsp_data, req_ready);
      end
      step();
      rst_n = 1'b1; rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL async_first_grant got=%b want=01", req_ready); end
      step();
      req_valid = '0;
      step();
   endtask

   task automatic test_random();
      logic        m_full;
      int          m_owner;
      int          m_last;
      logic [31:0] m_data;
      logic [1:0]  exp_ready;
      int          g;
      logic        free;
      do_reset();
      m_full = 1'b0; m_owner = 0; m_last = NREQ - 1; m_data = '0;
      for (int c = 0; c < 400; c++) begin
         req_valid = 2'($urandom_range(0, 3));
         rsp_ready = 2'($urandom_range(0, 3));
         flush     = ($urandom_range(0, 15) == 0);
         for (int r = 0; r < NREQ; r++) req_op[r] = shift_req_t'({$urandom, $urandom});
         free = !m_full || rsp_ready[m_owner];
         g = -1;
         if (free && !flush) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
         end
         exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
         #1;
         checks++;
         if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, req_ready, exp_ready); end
         if (flush) begin
            m_full = 1'b0;
         end else if (g >= 0) begin
            m_full = 1'b1; m_owner = g; m_last = g; m_data = ref_shift(req_op[g]);
         end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 1'b0;
         end
         step();
         checks++;
         if (rsp_valid !== (m_full ? 2'(1 << m_owner) : 2'b00)) begin
            errors++; $display("FAIL rnd_rsp_valid[%0d] got=%b full=%0d owner=%0d", c, rsp_valid, m_full, m_owner);
         end
         if (m_full) begin
            checks++;
            if (rsp_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", c, rsp_data, m_data); end
         end
      end
      idle_inputs();
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_sll();
      test_sra_srl();
      test_fairness();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
